// File: rtl/digit_motion_ctrl_pkg.sv
// Shared display constants and motion-controller state encodings, reused by
// every controller that positions a glyph on the 96-pixel OLED.
package digit_motion_ctrl_pkg;

    localparam int OLED_WIDTH  = 96;
    localparam int DIGIT_WIDTH = 16;
    localparam int MAX_X       = OLED_WIDTH - DIGIT_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MOVE   = 2'd1,
        ST_HOLD   = 2'd2,
        ST_PAUSED = 2'd3
    } motion_state_e;

endpackage

// File: rtl/digit_motion_ctrl_tick.sv
// Motion tick divider: while enabled, counts 0..TICK_DIV-1 and flags the
// last count; holds its value while disabled so a pause resumes mid-period.
module tick_gen #(
    parameter int TICK_DIV = 3000000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int               CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    logic [CNT_W-1:0] cnt_r;
    logic             at_last_s;

    // Terminal-count decode; tick only counts while the divider is enabled
    always_comb begin
        at_last_s = (cnt_r == CNT_LAST);
        tick      = en & at_last_s;
    end

    // Divider counter with wrap at the terminal count
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= CNT_ZERO;
        end else if (en) begin
            if (at_last_s) begin
                cnt_r <= CNT_ZERO;
            end else begin
                cnt_r <= cnt_r + CNT_ONE;
            end
        end
    end

endmodule

// File: rtl/digit_motion_ctrl.sv
// Horizontal digit animator: steps pos_x one pixel per motion tick, dwells at
// each edge, then bounces or wraps; run/pause control with frozen timing.
module digit_motion_ctrl
    import digit_motion_ctrl_pkg::*;
#(
    parameter int OLED_WIDTH  = digit_motion_ctrl_pkg::OLED_WIDTH,
    parameter int DIGIT_WIDTH = digit_motion_ctrl_pkg::DIGIT_WIDTH,
    parameter int TICK_DIV    = 3000000,
    parameter int DWELL_TICKS = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic       pause,
    input  logic       wrap_mode,
    output logic [6:0] pos_x,
    output logic       moving_right,
    output logic       edge_hit,
    output logic       busy
);

    localparam logic [6:0] MAX_POS    = 7'(OLED_WIDTH - DIGIT_WIDTH);
    localparam logic [7:0] DWELL_INIT = 8'(DWELL_TICKS);

    motion_state_e state_r, state_n;
    motion_state_e saved_r, saved_n;
    logic [6:0]    pos_r, pos_n, step_pos_s;
    logic [7:0]    dwell_r, dwell_n;
    logic          dir_r, dir_n;
    logic          edge_r, edge_n;
    logic          busy_r, busy_n;
    logic          at_bound_s;
    logic          tick_s, tick_en_s, tick_rst_s;

    // Divider runs only while actively moving/holding; IDLE keeps it cleared
    always_comb begin
        tick_en_s  = ((state_r == ST_MOVE) || (state_r == ST_HOLD)) && run && !pause;
        tick_rst_s = rst || (state_r == ST_IDLE);
    end

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (tick_rst_s),
        .en   (tick_en_s),
        .tick (tick_s)
    );

    // Next-state, position and dwell logic; run=0 beats pause beats tick
    always_comb begin
        state_n    = state_r;
        saved_n    = saved_r;
        pos_n      = pos_r;
        dir_n      = dir_r;
        dwell_n    = dwell_r;
        edge_n     = 1'b0;
        at_bound_s = dir_r ? (pos_r == MAX_POS) : (pos_r == 7'd0);
        step_pos_s = dir_r ? (pos_r + 7'd1) : (pos_r - 7'd1);

        case (state_r)
            ST_IDLE: begin
                if (run && !pause) begin
                    state_n = ST_MOVE;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_MOVE: begin
                if (!run) begin
                    state_n = ST_IDLE;
                end else if (pause) begin
                    saved_n = ST_MOVE;
                    state_n = ST_PAUSED;
                end else if (tick_s) begin
                    // Already at the target bound: no step, straight into the dwell
                    if (at_bound_s) begin
                        edge_n  = 1'b1;
                        dwell_n = DWELL_INIT;
                        state_n = ST_HOLD;
                    end else begin
                        pos_n = step_pos_s;
                        if (step_pos_s == (dir_r ? MAX_POS : 7'd0)) begin
                            edge_n  = 1'b1;
                            dwell_n = DWELL_INIT;
                            state_n = ST_HOLD;
                        end else begin
                            state_n = ST_MOVE;
                        end
                    end
                end else begin
                    state_n = ST_MOVE;
                end
            end
            ST_HOLD: begin
                if (!run) begin
                    state_n = ST_IDLE;
                end else if (pause) begin
                    saved_n = ST_HOLD;
                    state_n = ST_PAUSED;
                end else if (tick_s) begin
                    if (dwell_r <= 8'd1) begin
                        dwell_n = 8'd0;
                        state_n = ST_MOVE;
                        if (wrap_mode) begin
                            pos_n = dir_r ? 7'd0 : MAX_POS;
                        end else begin
                            dir_n = ~dir_r;
                        end
                    end else begin
                        dwell_n = dwell_r - 8'd1;
                        state_n = ST_HOLD;
                    end
                end else begin
                    state_n = ST_HOLD;
                end
            end
            ST_PAUSED: begin
                if (!run) begin
                    state_n = ST_IDLE;
                end else if (!pause) begin
                    state_n = saved_r;
                end else begin
                    state_n = ST_PAUSED;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase

        busy_n = (state_n != ST_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            saved_r <= ST_MOVE;
            pos_r   <= 7'd0;
            dir_r   <= 1'b1;
            dwell_r <= 8'd0;
            edge_r  <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_n;
            saved_r <= saved_n;
            pos_r   <= pos_n;
            dir_r   <= dir_n;
            dwell_r <= dwell_n;
            edge_r  <= edge_n;
            busy_r  <= busy_n;
        end
    end

    assign pos_x        = pos_r;
    assign moving_right = dir_r;
    assign edge_hit     = edge_r;
    assign busy         = busy_r;

endmodule
